// File: rtl/fft4_result_serializer.sv
// fft4_result_serializer
// Buffers 4-wide complex result groups from the twiddle/merge stage in a
// small FIFO and replays each group as four serial complex samples on a
// valid/ready stream, tagged with {group index, k} and a frame-last marker.
//
// Output handshake: a sample transfers on a rising edge where out_valid and
// out_ready are both 1. out_valid is 1 whenever a group is stored, never
// drops without a transfer, and out_r/out_i/out_addr/out_last stay stable
// while out_valid=1 and out_ready=0. The input side has no back-pressure:
// a group offered while the FIFO is full is dropped and flagged in overflow.
module fft4_result_serializer #(
    parameter int DATA_WIDTH   = 27,
    parameter int INDEX_WIDTH  = 11,
    parameter int DEPTH        = 8,
    parameter int FRAME_GROUPS = 512
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [INDEX_WIDTH-1:0]       in_index,
    input  logic [DATA_WIDTH-1:0]        in_y0_r,
    input  logic [DATA_WIDTH-1:0]        in_y0_i,
    input  logic [DATA_WIDTH-1:0]        in_y1_r,
    input  logic [DATA_WIDTH-1:0]        in_y1_i,
    input  logic [DATA_WIDTH-1:0]        in_y2_r,
    input  logic [DATA_WIDTH-1:0]        in_y2_i,
    input  logic [DATA_WIDTH-1:0]        in_y3_r,
    input  logic [DATA_WIDTH-1:0]        in_y3_i,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_r,
    output logic [DATA_WIDTH-1:0]        out_i,
    output logic [INDEX_WIDTH+1:0]       out_addr,
    output logic                         out_last,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int FW = (FRAME_GROUPS > 1) ? $clog2(FRAME_GROUPS) : 1;
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [FW-1:0] FRAME_END  = FW'(FRAME_GROUPS - 1);

    // Group storage: index plus the four real and four imag parts, packed
    // as {y3, y2, y1, y0} so sample k sits in slice k.
    logic [INDEX_WIDTH-1:0]  mem_idx [DEPTH];
    logic [4*DATA_WIDTH-1:0] mem_r   [DEPTH];
    logic [4*DATA_WIDTH-1:0] mem_i   [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [1:0]    k;
    logic [FW-1:0] frame_cnt;
    logic          overflow_q;

    logic full;
    logic push;
    logic fire;
    logic pop;

    logic [4*DATA_WIDTH-1:0] head_r;
    logic [4*DATA_WIDTH-1:0] head_i;
    logic [DATA_WIDTH-1:0]   sel_r;
    logic [DATA_WIDTH-1:0]   sel_i;

    // A pop in the same cycle does not make room: full is the registered level.
    assign full      = (level_q == LEVEL_FULL);
    assign push      = in_valid && !full;
    assign out_valid = (level_q != '0);
    assign fire      = out_valid && out_ready;
    assign pop       = fire && (k == 2'd3);

    // Capture an accepted group into the entry at the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_idx[wr_ptr] <= in_index;
            mem_r[wr_ptr]   <= {in_y3_r, in_y2_r, in_y1_r, in_y0_r};
            mem_i[wr_ptr]   <= {in_y3_i, in_y2_i, in_y1_i, in_y0_i};
        end
    end

    // Pointers, occupancy, sample counter, frame counter and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            k          <= 2'd0;
            frame_cnt  <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (in_valid && full) begin
                overflow_q <= 1'b1;
            end
            if (fire) begin
                k <= k + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (frame_cnt == FRAME_END) begin
                    frame_cnt <= '0;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Select sample k of the head group.
    always_comb begin
        head_r = mem_r[rd_ptr];
        head_i = mem_i[rd_ptr];
        sel_r  = head_r[DATA_WIDTH-1:0];
        sel_i  = head_i[DATA_WIDTH-1:0];
        case (k)
            2'd1: begin
                sel_r = head_r[2*DATA_WIDTH-1:DATA_WIDTH];
                sel_i = head_i[2*DATA_WIDTH-1:DATA_WIDTH];
            end
            2'd2: begin
                sel_r = head_r[3*DATA_WIDTH-1:2*DATA_WIDTH];
                sel_i = head_i[3*DATA_WIDTH-1:2*DATA_WIDTH];
            end
            2'd3: begin
                sel_r = head_r[4*DATA_WIDTH-1:3*DATA_WIDTH];
                sel_i = head_i[4*DATA_WIDTH-1:3*DATA_WIDTH];
            end
            default: begin
                sel_r = head_r[DATA_WIDTH-1:0];
                sel_i = head_i[DATA_WIDTH-1:0];
            end
        endcase
    end

    // Outputs read as zero while nothing is stored, so reset shows clean zeros.
    assign out_r    = out_valid ? sel_r : '0;
    assign out_i    = out_valid ? sel_i : '0;
    assign out_addr = out_valid ? {mem_idx[rd_ptr], k} : '0;
    assign out_last = out_valid && (k == 2'd3) && (frame_cnt == FRAME_END);
    assign level    = level_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_fft4_result_serializer.sv
// Directed bench for fft4_result_serializer: single group, stalled stream,
// overflow, simultaneous push/pop, mid-group reset and a full frame.
module tb_fft4_result_serializer;

    localparam int DW = 27;
    localparam int IW = 11;
    localparam int DEPTH = 8;
    localparam int FRAME = 512;
    localparam int EW = 2*DW + IW + 2 + 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [IW-1:0] in_index;
    logic [DW-1:0] in_y0_r, in_y0_i, in_y1_r, in_y1_i;
    logic [DW-1:0] in_y2_r, in_y2_i, in_y3_r, in_y3_i;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_r;
    logic [DW-1:0] out_i;
    logic [IW+1:0] out_addr;
    logic          out_last;
    logic [3:0]    level;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int group_seq = 0;
    int n_last   = 0;

    logic [EW-1:0] exp_q[$];

    fft4_result_serializer #(
        .DATA_WIDTH(DW), .INDEX_WIDTH(IW), .DEPTH(DEPTH), .FRAME_GROUPS(FRAME)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_index(in_index),
        .in_y0_r(in_y0_r), .in_y0_i(in_y0_i),
        .in_y1_r(in_y1_r), .in_y1_i(in_y1_i),
        .in_y2_r(in_y2_r), .in_y2_i(in_y2_i),
        .in_y3_r(in_y3_r), .in_y3_i(in_y3_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_i(out_i), .out_addr(out_addr), .out_last(out_last),
        .level(level), .overflow(overflow)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [EW-1:0] mk(input int r, input int i, input int idx, input int k, input bit last);
        logic [IW-1:0] ix;
        logic [1:0]    kk;
        ix = idx[IW-1:0];
        kk = k[1:0];
        return {DW'(r), DW'(i), ix, kk, last};
    endfunction

    // Drive one group for one cycle; sample k has real base+k and imag -(base+k).
    task automatic push_group(input int idx, input int base, input bit dropped);
        in_valid = 1'b1;
        in_index = idx[IW-1:0];
        in_y0_r = DW'(base);     in_y0_i = DW'(-base);
        in_y1_r = DW'(base + 1); in_y1_i = DW'(-(base + 1));
        in_y2_r = DW'(base + 2); in_y2_i = DW'(-(base + 2));
        in_y3_r = DW'(base + 3); in_y3_i = DW'(-(base + 3));
        if (!dropped) begin
            for (int k = 0; k < 4; k++) begin
                exp_q.push_back(mk(base + k, -(base + k), idx, k,
                                   (k == 3) && ((group_seq % FRAME) == FRAME - 1)));
            end
            group_seq++;
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Scoreboard: compare each transferred sample, and check that a stalled
    // sample is still presented unchanged one cycle later.
    logic          hold_pending = 1'b0;
    logic [EW-1:0] hold_val;

    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", {out_r, out_i, out_addr, out_last}, hold_val);
            end
            hold_pending = 1'b0;
            if (out_valid && out_ready) begin
                if (out_last) n_last++;
                if (exp_q.size() == 0) begin
                    check("unexpected_sample", {out_r, out_i, out_addr, out_last}, '0);
                end else begin
                    check("sample", {out_r, out_i, out_addr, out_last}, exp_q.pop_front());
                end
            end else if (out_valid) begin
                hold_pending = 1'b1;
                hold_val = {out_r, out_i, out_addr, out_last};
            end
        end
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_index = '0;
        in_y0_r = '0; in_y0_i = '0; in_y1_r = '0; in_y1_i = '0;
        in_y2_r = '0; in_y2_i = '0; in_y3_r = '0; in_y3_i = '0;
        out_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_addr", out_addr, 0);
        check("rst_r", out_r, 0);
        check("rst_last", out_last, 0);
        rst = 1'b0;
        tick();

        // Single group idx 5, addr 20..23, level 1 -> 0
        out_ready = 1'b1;
        push_group(5, 1, 0);
        check("t1_level1", level, 1);
        check("t1_valid", out_valid, 1);
        check("t1_addr0", out_addr, 20);
        check("t1_r0", out_r, 1);
        check("t1_i0", out_i, 27'h7ffffff);
        repeat (4) tick();
        check("t1_level0", level, 0);
        check("t1_valid0", out_valid, 0);

        // out_ready toggling 1010...
        out_ready = 1'b0;
        push_group(9, 100, 0);
        for (int c = 0; c < 8; c++) begin
            out_ready = (c % 2 == 0);
            tick();
            if (c == 1) check("t2_addr_held", out_addr, 37);
        end
        check("t2_level0", level, 0);

        // Overflow: DEPTH+1 groups with the stream stalled
        out_ready = 1'b0;
        for (int g = 0; g <= DEPTH; g++) begin
            push_group(32 + g, 1000 + g*10, g == DEPTH);
        end
        check("t3_level_full", level, DEPTH);
        check("t3_overflow", overflow, 1);
        check("t3_head_addr", out_addr, 128);
        out_ready = 1'b1;
        repeat (34) tick();
        check("t3_level0", level, 0);
        check("t3_drained", exp_q.size(), 0);
        check("t3_overflow_sticky", overflow, 1);

        // Push lands on the same edge as the final pop of the previous group
        push_group(50, 2000, 0);
        repeat (3) tick();
        check("t4_level_before", level, 1);
        push_group(51, 3000, 0);
        check("t4_level_after", level, 1);
        check("t4_addr_b0", out_addr, 204);
        check("t4_r_b0", out_r, 3000);
        repeat (4) tick();
        check("t4_level0", level, 0);

        // Reset in the middle of a group (k=2)
        push_group(3, 4000, 0);
        tick();
        tick();
        check("t5_addr_k2", out_addr, 14);
        rst = 1'b1;
        #1;
        check("t5_valid", out_valid, 0);
        check("t5_level", level, 0);
        check("t5_overflow", overflow, 0);
        check("t5_addr", out_addr, 0);
        exp_q.delete();
        group_seq = 0;
        tick();
        rst = 1'b0;
        tick();
        push_group(6, 5000, 0);
        check("t5_new_addr", out_addr, 24);
        check("t5_new_r", out_r, 5000);
        repeat (4) tick();
        check("t5_level0", level, 0);

        // Fresh reset, then one full frame plus the first group of the next
        rst = 1'b1;
        tick();
        rst = 1'b0;
        group_seq = 0;
        exp_q.delete();
        n_last = 0;
        tick();
        out_ready = 1'b1;
        for (int g = 0; g <= FRAME; g++) begin
            push_group(g, g*8, 0);
            repeat (3) tick();
        end
        repeat (4) tick();
        check("t6_level0", level, 0);
        check("t6_drained", exp_q.size(), 0);
        check("t6_last_count", n_last, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
